// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared states, frame geometry and result-byte layout for the frame loader
package cnn_pkg;

  typedef enum logic [1:0] {LOAD, START, WAIT_DONE, REPORT} state_t;

  localparam int NUM_PIXELS  = 784;
  localparam int LABEL_W     = 4;
  localparam int TIMEOUT_BIT = 7;
  localparam int MATCH_BIT   = 6;

  function automatic logic [7:0] result_byte(input logic timeout, input logic match,
                                              input logic [LABEL_W-1:0] pred);
    logic [7:0] r;
    r              = {{(8-LABEL_W){1'b0}}, pred};
    r[TIMEOUT_BIT] = timeout;
    r[MATCH_BIT]   = match;
    return r;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - pixel buffer: one synchronous write port, one registered read port
module frame_ram #(
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rd_data
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [7:0] mem [DEPTH];

  // Array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if ({1'b0, raddr} < DEPTH_L) begin
      rd_data <= mem[raddr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/cnn_frame_loader.sv
// rtl/cnn_frame_loader.sv - buffers one image plus label, runs cnn_top, reports a result byte
module cnn_frame_loader
  import cnn_pkg::*;
#(
  parameter int NUM_PIXELS     = cnn_pkg::NUM_PIXELS,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               cnn_start,
  input  logic [ADDR_W-1:0]  cnn_rd_addr,
  output logic [7:0]         cnn_rd_data,
  output logic [LABEL_W-1:0] cnn_label,
  input  logic [7:0]         cnn_class,
  input  logic               cnn_done,
  output logic [7:0]         m_data,
  output logic               m_valid,
  input  logic               m_ready,
  input  logic               clear_stats,
  output logic [CNT_W-1:0]   num_correct,
  output logic [CNT_W-1:0]   num_images,
  output logic               busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0] IDX_LABEL = (ADDR_W+1)'(NUM_PIXELS);

  state_t          state, state_nxt;
  logic [ADDR_W:0] idx;
  logic [TW-1:0]   tcnt;
  logic            s_fire, m_fire, is_label, timed_out, match;

  assign s_fire    = s_valid && s_ready;
  assign m_fire    = m_valid && m_ready;
  assign is_label  = (idx == IDX_LABEL);
  assign timed_out = (tcnt == TCNT_LAST);
  assign match     = (cnn_class == {{(8-LABEL_W){1'b0}}, cnn_label});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    cnn_start = 1'b0;
    busy      = 1'b1;
    unique case (state)
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_fire && is_label) state_nxt = START;
      end
      START: begin
        cnn_start = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (cnn_done || timed_out) state_nxt = REPORT;
      REPORT:    if (m_fire) state_nxt = LOAD;
      default:   state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      cnn_label   <= '0;
      tcnt        <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      num_correct <= '0;
      num_images  <= '0;
    end else begin
      if (s_fire) idx <= is_label ? '0 : idx + 1'b1;
      if (s_fire && is_label) cnn_label <= s_data[LABEL_W-1:0];

      if (state == START) tcnt <= '0;
      else if (state == WAIT_DONE && !timed_out) tcnt <= tcnt + 1'b1;

      // A real done wins over a timeout landing on the same cycle.
      if (state == WAIT_DONE && cnn_done) begin
        m_data  <= result_byte(1'b0, match, cnn_class[LABEL_W-1:0]);
        m_valid <= 1'b1;
      end else if (state == WAIT_DONE && timed_out) begin
        m_data  <= result_byte(1'b1, 1'b0, {LABEL_W{1'b1}});
        m_valid <= 1'b1;
      end else if (m_fire) begin
        m_valid <= 1'b0;
      end

      if (clear_stats) begin
        num_correct <= '0;
        num_images  <= '0;
      end else if (m_fire) begin
        if (num_images != '1) num_images <= num_images + 1'b1;
        if (m_data[MATCH_BIT] && num_correct != '1) num_correct <= num_correct + 1'b1;
      end
    end
  end

  frame_ram #(
    .DEPTH  (NUM_PIXELS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (s_fire && !is_label),
    .waddr   (idx[ADDR_W-1:0]),
    .wdata   (s_data),
    .raddr   (cnn_rd_addr),
    .rd_data (cnn_rd_data)
  );

endmodule

// File: tb/tb_cnn_frame_loader.sv
// tb/tb_cnn_frame_loader.sv - directed self-checking bench for cnn_frame_loader
module tb_cnn_frame_loader;

  localparam int NPIX = 784;

  logic        clk, rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_ready, cnn_start;
  logic [9:0]  cnn_rd_addr;
  logic [7:0]  cnn_rd_data;
  logic [3:0]  cnn_label;
  logic [7:0]  cnn_class;
  logic        cnn_done;
  logic [7:0]  m_data;
  logic        m_valid, m_ready, clear_stats;
  logic [15:0] num_correct, num_images;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  cnn_frame_loader #(
    .NUM_PIXELS     (NPIX),
    .ADDR_W         (10),
    .TIMEOUT_CYCLES (100),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .cnn_start   (cnn_start),
    .cnn_rd_addr (cnn_rd_addr),
    .cnn_rd_data (cnn_rd_data),
    .cnn_label   (cnn_label),
    .cnn_class   (cnn_class),
    .cnn_done    (cnn_done),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .clear_stats (clear_stats),
    .num_correct (num_correct),
    .num_images  (num_images),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int w;
    s_data  = b;
    s_valid = 1'b1;
    w = 0;
    while (!s_ready && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    stalls += w;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] p0, input logic [7:0] label, input int nbytes);
    logic [7:0] b;
    for (int i = 0; i < nbytes && i <= NPIX; i++) begin
      b = i[7:0];
      if (i == 0)    b = p0;
      if (i == NPIX) b = label;
      send_byte(b);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!m_valid && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  // Full frame, cnn answers after 50 cycles; leaves the loader in REPORT.
  task automatic do_frame(input logic [7:0] p0, input logic [7:0] label, input logic [7:0] cls,
                          output int starts);
    int wc;
    send_frame(p0, label, NPIX + 1);
    starts = 0;
    for (int c = 0; c < 50; c++) begin
      if (cnn_start) starts++;
      @(posedge clk); #1;
    end
    cnn_class = cls;
    cnn_done  = 1'b1;
    @(posedge clk); #1;
    cnn_done  = 1'b0;
    wait_result(wc);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
    checks++; if (cnn_start !== 1'b0) begin errors++; $display("FAIL reset_cnn_start got %b exp 0", cnn_start); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h exp 00", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (num_images !== 16'd0) begin errors++; $display("FAIL reset_num_images got %0d exp 0", num_images); end
    rst_n = 1'b1;
  endtask

  task automatic test_match();
    int starts;
    stalls = 0;
    send_frame(8'h00, 8'h07, NPIX + 1);
    checks++; if (cnn_start !== 1'b1) begin errors++; $display("FAIL start_after_label got %b exp 1", cnn_start); end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL load_stalls got %0d exp 0", stalls); end
    checks++; if (cnn_label !== 4'h7) begin errors++; $display("FAIL label_latch got %h exp 7", cnn_label); end
    cnn_rd_addr = 10'd300;
    starts = 0;
    for (int c = 0; c < 50; c++) begin
      if (cnn_start) starts++;
      @(posedge clk); #1;
    end
    checks++; if (starts !== 1) begin errors++; $display("FAIL start_pulses got %0d exp 1", starts); end
    checks++; if (cnn_rd_data !== 8'h2C) begin errors++; $display("FAIL rd_addr_300 got %h exp 2c", cnn_rd_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_wait got %b exp 1", busy); end
    cnn_rd_addr = 10'd784;
    cnn_class = 8'h07;
    cnn_done  = 1'b1;
    @(posedge clk); #1;
    cnn_done  = 1'b0;
    checks++; if (cnn_rd_data !== 8'h00) begin errors++; $display("FAIL rd_addr_784 got %h exp 00", cnn_rd_data); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL match_m_valid got %b exp 1", m_valid); end
    checks++; if (m_data !== 8'h47) begin errors++; $display("FAIL match_m_data got %h exp 47", m_data); end
    handshake();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL match_valid_drop got %b exp 0", m_valid); end
    checks++; if (num_correct !== 16'd1) begin errors++; $display("FAIL match_num_correct got %0d exp 1", num_correct); end
    checks++; if (num_images !== 16'd1) begin errors++; $display("FAIL match_num_images got %0d exp 1", num_images); end
  endtask

  task automatic test_mismatch();
    int starts;
    do_frame(8'h00, 8'h07, 8'h03, starts);
    checks++; if (m_data !== 8'h03) begin errors++; $display("FAIL mismatch_m_data got %h exp 03", m_data); end
    handshake();
    checks++; if (num_correct !== 16'd1) begin errors++; $display("FAIL mismatch_num_correct got %0d exp 1", num_correct); end
    checks++; if (num_images !== 16'd2) begin errors++; $display("FAIL mismatch_num_images got %0d exp 2", num_images); end
  endtask

  task automatic test_label_bits();
    int starts;
    do_frame(8'h00, 8'hA5, 8'h05, starts);
    checks++; if (cnn_label !== 4'h5) begin errors++; $display("FAIL label_upper_ignored got %h exp 5", cnn_label); end
    checks++; if (m_data !== 8'h45) begin errors++; $display("FAIL label_match_data got %h exp 45", m_data); end
    handshake();
    do_frame(8'h00, 8'h07, 8'h17, starts);
    checks++; if (m_data !== 8'h07) begin errors++; $display("FAIL class_upper_mismatch got %h exp 07", m_data); end
    handshake();
    checks++; if (num_correct !== 16'd2) begin errors++; $display("FAIL label_num_correct got %0d exp 2", num_correct); end
    checks++; if (num_images !== 16'd4) begin errors++; $display("FAIL label_num_images got %0d exp 4", num_images); end
  endtask

  task automatic test_timeout();
    int cyc;
    send_frame(8'h00, 8'h07, NPIX + 1);
    cnn_done = 1'b1;
    @(posedge clk); #1;
    cnn_done = 1'b0;
    cyc = 0;
    while (!m_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 100) begin errors++; $display("FAIL timeout_latency got %0d exp 100", cyc); end
    checks++; if (m_data !== 8'h8F) begin errors++; $display("FAIL timeout_m_data got %h exp 8f", m_data); end
    handshake();
    checks++; if (num_images !== 16'd5) begin errors++; $display("FAIL timeout_num_images got %0d exp 5", num_images); end
    checks++; if (num_correct !== 16'd2) begin errors++; $display("FAIL timeout_num_correct got %0d exp 2", num_correct); end
  endtask

  task automatic test_back_to_back();
    int starts, bad, wc;
    logic [7:0] hold;
    do_frame(8'h00, 8'h07, 8'h07, starts);
    hold    = m_data;
    m_ready = 1'b0;
    s_data  = 8'hAA;
    s_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (m_data !== hold || s_ready !== 1'b0 || m_valid !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL backpressure_hold got %0d bad cycles exp 0", bad); end
    handshake();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_handshake got %b exp 1", s_ready); end
    checks++; if (num_images !== 16'd6) begin errors++; $display("FAIL b2b_num_images got %0d exp 6", num_images); end
    stalls = 0;
    send_frame(8'hAA, 8'h07, NPIX + 1);
    checks++; if (stalls !== 0) begin errors++; $display("FAIL b2b_stalls got %0d exp 0", stalls); end
    cnn_rd_addr = 10'd0;
    @(posedge clk); #1;
    checks++; if (cnn_rd_data !== 8'hAA) begin errors++; $display("FAIL b2b_pixel0 got %h exp aa", cnn_rd_data); end
    cnn_rd_addr = 10'd1;
    @(posedge clk); #1;
    checks++; if (cnn_rd_data !== 8'h01) begin errors++; $display("FAIL b2b_pixel1 got %h exp 01", cnn_rd_data); end
    cnn_class = 8'h07;
    cnn_done  = 1'b1;
    @(posedge clk); #1;
    cnn_done  = 1'b0;
    wait_result(wc);
    checks++; if (m_data !== 8'h47) begin errors++; $display("FAIL b2b_m_data got %h exp 47", m_data); end
    handshake();
    checks++; if (num_correct !== 16'd4) begin errors++; $display("FAIL b2b_num_correct got %0d exp 4", num_correct); end
  endtask

  task automatic test_reset_mid_frame();
    int starts;
    send_frame(8'h00, 8'h07, 400);
    rst_n = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midreset_s_ready got %b exp 1", s_ready); end
    checks++; if (cnn_rd_data !== 8'h00) begin errors++; $display("FAIL midreset_rd_data got %h exp 00", cnn_rd_data); end
    checks++; if (cnn_label !== 4'h0) begin errors++; $display("FAIL midreset_label got %h exp 0", cnn_label); end
    checks++; if (num_correct !== 16'd0) begin errors++; $display("FAIL midreset_num_correct got %0d exp 0", num_correct); end
    checks++; if (num_images !== 16'd0) begin errors++; $display("FAIL midreset_num_images got %0d exp 0", num_images); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_frame(8'h00, 8'h03, 8'h03, starts);
    checks++; if (starts !== 1) begin errors++; $display("FAIL midreset_starts got %0d exp 1", starts); end
    checks++; if (m_data !== 8'h43) begin errors++; $display("FAIL midreset_m_data got %h exp 43", m_data); end
    handshake();
    checks++; if (num_images !== 16'd1) begin errors++; $display("FAIL midreset_num_images_after got %0d exp 1", num_images); end
  endtask

  task automatic test_clear_stats();
    int starts;
    do_frame(8'h00, 8'h02, 8'h02, starts);
    checks++; if (m_data !== 8'h42) begin errors++; $display("FAIL clear_m_data got %h exp 42", m_data); end
    clear_stats = 1'b1;
    handshake();
    clear_stats = 1'b0;
    checks++; if (num_correct !== 16'd0) begin errors++; $display("FAIL clear_num_correct got %0d exp 0", num_correct); end
    checks++; if (num_images !== 16'd0) begin errors++; $display("FAIL clear_num_images got %0d exp 0", num_images); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL clear_s_ready got %b exp 1", s_ready); end
  endtask

  initial begin
    rst_n       = 1'b0;
    s_data      = 8'h00;
    s_valid     = 1'b0;
    cnn_rd_addr = 10'd0;
    cnn_class   = 8'h00;
    cnn_done    = 1'b0;
    m_ready     = 1'b0;
    clear_stats = 1'b0;
    test_reset();
    test_match();
    test_mismatch();
    test_label_bits();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    test_clear_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
